// File: rtl/mc_control_unit_pkg.sv
// Shared definitions for the multicycle MIPS control unit: opcodes, ALU codes,
// mux select codes, FSM state encoding and the registered control-word bundle.
package mc_defs;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;

    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_CMP = 3'b111;

    localparam logic [3:0] SRCB_B    = 4'd0;
    localparam logic [3:0] SRCB_4    = 4'd1;
    localparam logic [3:0] SRCB_SEXT = 4'd2;
    localparam logic [3:0] SRCB_SHL2 = 4'd3;

    localparam logic [3:0] PCS_ALU    = 4'd0;
    localparam logic [3:0] PCS_ALUOUT = 4'd1;
    localparam logic [3:0] PCS_JUMP   = 4'd2;
    localparam logic [3:0] PCS_EXC    = 4'd4;

    // state     | meaning
    // RESET     | all outputs low, restart fetch
    // FETCH0/_W | present PC to memory, wait MEM_WAIT cycles
    // FETCH2    | load IR, PC <= PC+4
    // DECODE    | ALUout <= branch target, dispatch on opcode
    // *_EXEC/WB | ALU op then register write-back
    // MEM_ADDR  | effective address; LW_W/LW_WB load, SW_WR store
    // BRANCH    | compare A/B, conditional PC write
    // JUMP      | PC <= jump address
    // EXC_EPC   | ALUout <= PC-4; EXC_VEC writes EPC, PC <= vector
    typedef enum logic [4:0] {
        RESET, FETCH0, FETCH_W, FETCH2, DECODE,
        R_EXEC, R_WB, ADDI_EXEC, ADDI_WB,
        MEM_ADDR, LW_W, LW_WB, SW_WR,
        BRANCH, JUMP, EXC_EPC, EXC_VEC
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       reg_dest;
        logic       alu_src_a;
        logic       epc_write;
        logic       iord;
        logic [3:0] alu_src_b;
        logic [3:0] pc_source;
        logic [2:0] alu_control;
    } ctrl_t;

    function automatic logic funct_valid(input logic [5:0] funct);
        return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND);
    endfunction

    function automatic logic [2:0] alu_from_funct(input logic [5:0] funct);
        logic [2:0] code;
        case (funct)
            FN_SUB:  code = ALU_SUB;
            FN_AND:  code = ALU_AND;
            default: code = ALU_ADD;
        endcase
        return code;
    endfunction

    // Flag-independent outputs of a state; flag-dependent writes are added by the FSM.
    function automatic ctrl_t moore_ctrl(input state_t s, input logic [5:0] funct);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH2: begin
                c.ir_write    = 1'b1;
                c.alu_src_b   = SRCB_4;
                c.alu_control = ALU_ADD;
                c.pc_source   = PCS_ALU;
                c.pc_write    = 1'b1;
            end
            DECODE: begin
                c.alu_src_b   = SRCB_SHL2;
                c.alu_control = ALU_ADD;
            end
            R_EXEC: begin
                c.alu_src_a   = 1'b1;
                c.alu_src_b   = SRCB_B;
                c.alu_control = alu_from_funct(funct);
            end
            R_WB: begin
                c.alu_src_a   = 1'b1;
                c.alu_src_b   = SRCB_B;
                c.alu_control = alu_from_funct(funct);
                c.reg_dest    = 1'b1;
            end
            ADDI_EXEC, ADDI_WB, MEM_ADDR: begin
                c.alu_src_a   = 1'b1;
                c.alu_src_b   = SRCB_SEXT;
                c.alu_control = ALU_ADD;
            end
            LW_W: c.iord = 1'b1;
            LW_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            SW_WR: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a   = 1'b1;
                c.alu_src_b   = SRCB_B;
                c.alu_control = ALU_CMP;
                c.pc_source   = PCS_ALUOUT;
            end
            JUMP: begin
                c.pc_source = PCS_JUMP;
                c.pc_write  = 1'b1;
            end
            EXC_EPC: begin
                c.alu_src_b   = SRCB_4;
                c.alu_control = ALU_SUB;
            end
            EXC_VEC: begin
                c.epc_write = 1'b1;
                c.pc_source = PCS_EXC;
                c.pc_write  = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_control_unit_if.sv
// Control-unit <-> datapath bundle: IR fields and ALU flags in, control wires out.
interface mc_control_unit_if;
    logic [5:0] OPCODE;
    logic [5:0] FUNCT;
    logic       Overflow;
    logic       Igual;
    logic       PCwrite;
    logic       MemWrite;
    logic       MemRead;
    logic       IRWrite;
    logic       RegWrite;
    logic       MemToReg;
    logic       RegDest;
    logic       AluSrcA;
    logic       EPCWrite;
    logic       IorD;
    logic [2:0] ShiftControl;
    logic [3:0] AluSrcB;
    logic [3:0] PCSource;
    logic [2:0] ALUControl;
    logic [4:0] State;

    modport master (
        input  OPCODE, FUNCT, Overflow, Igual,
        output PCwrite, MemWrite, MemRead, IRWrite, RegWrite, MemToReg, RegDest,
               AluSrcA, EPCWrite, IorD, ShiftControl, AluSrcB, PCSource, ALUControl, State
    );

    modport slave (
        output OPCODE, FUNCT, Overflow, Igual,
        input  PCwrite, MemWrite, MemRead, IRWrite, RegWrite, MemToReg, RegDest,
               AluSrcA, EPCWrite, IorD, ShiftControl, AluSrcB, PCSource, ALUControl, State
    );
endinterface

// File: rtl/mc_control_unit_mem_wait.sv
// Memory latency counter: start clears it the cycle before a wait state is entered,
// done flags the last of MEM_WAIT cycles while the wait state is active.
module mc_mem_wait #(
    parameter int MEM_WAIT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic active,
    output logic done
);
    logic [1:0] cnt_q;
    logic [1:0] cnt_d;

    assign done = active && (cnt_q == 2'(MEM_WAIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = '0;
        end else if (active && !done) begin
            cnt_d = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/mc_control_unit.sv
// Multicycle MIPS control FSM. Flag-independent outputs are registered from the
// next state; writes that hinge on Igual/Overflow or the wait counter are gated live.
module mc_control_unit
    import mc_defs::*;
#(
    parameter int MEM_WAIT      = 1,
    parameter bit EXC_OPCODE_EN = 1'b1
) (
    input logic         clk,
    input logic         reset,
    mc_control_unit_if.master bus
);
    localparam state_t BAD_OP_NEXT = EXC_OPCODE_EN ? EXC_EPC : FETCH0;

    if (MEM_WAIT < 1 || MEM_WAIT > 3) begin : g_bad_mem_wait
        $error("mc_control_unit: MEM_WAIT must be 1..3");
    end

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl_q;
    ctrl_t  ctrl_d;

    logic wait_start;
    logic wait_active;
    logic wait_done;
    logic is_r_arith;
    logic ovf_trap;
    logic branch_taken;
    logic wb_state;

    assign is_r_arith   = (bus.FUNCT == FN_ADD) || (bus.FUNCT == FN_SUB);
    assign wb_state     = (state_q == R_WB) || (state_q == ADDI_WB);
    assign ovf_trap     = bus.Overflow && (((state_q == R_WB) && is_r_arith) || (state_q == ADDI_WB));
    assign branch_taken = ((bus.OPCODE == OP_BEQ) && bus.Igual) ||
                          ((bus.OPCODE == OP_BNE) && !bus.Igual);
    assign wait_active  = (state_q == FETCH_W) || (state_q == LW_W);
    assign wait_start   = (state_q == FETCH0) || ((state_q == MEM_ADDR) && (bus.OPCODE == OP_LW));

    mc_mem_wait #(.MEM_WAIT(MEM_WAIT)) u_mem_wait (
        .clk    (clk),
        .reset  (reset),
        .start  (wait_start),
        .active (wait_active),
        .done   (wait_done)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            RESET:   state_d = FETCH0;
            FETCH0:  state_d = FETCH_W;
            FETCH_W: if (wait_done) state_d = FETCH2;
            FETCH2:  state_d = DECODE;
            DECODE: begin
                case (bus.OPCODE)
                    OP_RTYPE:     state_d = funct_valid(bus.FUNCT) ? R_EXEC : BAD_OP_NEXT;
                    OP_ADDI:      state_d = ADDI_EXEC;
                    OP_LW, OP_SW: state_d = MEM_ADDR;
                    OP_BEQ, OP_BNE: state_d = BRANCH;
                    OP_J:         state_d = JUMP;
                    default:      state_d = BAD_OP_NEXT;
                endcase
            end
            R_EXEC:    state_d = R_WB;
            ADDI_EXEC: state_d = ADDI_WB;
            R_WB, ADDI_WB: state_d = ovf_trap ? EXC_EPC : FETCH0;
            MEM_ADDR:  state_d = (bus.OPCODE == OP_LW) ? LW_W : SW_WR;
            LW_W:      if (wait_done) state_d = LW_WB;
            LW_WB, SW_WR, BRANCH, JUMP, EXC_VEC: state_d = FETCH0;
            EXC_EPC:   state_d = EXC_VEC;
            default:   state_d = RESET;
        endcase
        ctrl_d = moore_ctrl(state_d, bus.FUNCT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RESET;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // Branch and write-back enables follow the live ALU flags of the current cycle.
    assign bus.PCwrite      = ctrl_q.pc_write || ((state_q == BRANCH) && branch_taken);
    assign bus.RegWrite     = ctrl_q.reg_write || (wb_state && !ovf_trap);
    assign bus.MemRead      = (state_q == LW_W) && wait_done;
    assign bus.MemWrite     = ctrl_q.mem_write;
    assign bus.IRWrite      = ctrl_q.ir_write;
    assign bus.MemToReg     = ctrl_q.mem_to_reg;
    assign bus.RegDest      = ctrl_q.reg_dest;
    assign bus.AluSrcA      = ctrl_q.alu_src_a;
    assign bus.EPCWrite     = ctrl_q.epc_write;
    assign bus.IorD         = ctrl_q.iord;
    assign bus.AluSrcB      = ctrl_q.alu_src_b;
    assign bus.PCSource     = ctrl_q.pc_source;
    assign bus.ALUControl   = ctrl_q.alu_control;
    assign bus.ShiftControl = 3'b000;
    assign bus.State        = state_q;
endmodule
